tia_horizontal_motion: RTL and testbench
========================================

// Module: tia_horizontal_motion
// PURPOSE
//  Horizontal-motion (HMOVE) engine for the TIA core. Downstream of the write
//  address decoder, it consumes the p0hm/p1hm/m0hm/m1hm/blhm/hmove/hmclr strobes
//  plus data bits D7-D4, and holds the five 4-bit motion registers. On HMOVE it
//  emits extra-clock pulses to the P0/P1/M0/M1/BL position counters and a short
//  HMOVE blank window.
// PARAMETERS
//  STEP_CLKS   4   clk cycles per motion step (one compare slot)
//  NUM_STEPS   16  motion steps per HMOVE sequence
//  BLANK_CLKS  8   length of hmove_blank after an HMOVE strobe
// PORTS
//  clk        in   1  colour clock
//  reset      in   1  synchronous, active-high reset
//  d          in   4  data bus bits D7..D4 (motion value, two's complement)
//  p0hm       in   1  write strobe HMP0 (single-clk pulse from decoder)
//  p1hm       in   1  write strobe HMP1
//  m0hm       in   1  write strobe HMM0
//  m1hm       in   1  write strobe HMM1
//  blhm       in   1  write strobe HMBL
//  hmove      in   1  HMOVE strobe: start a motion sequence
//  hmclr      in   1  HMCLR strobe: clear all five motion registers
//  p0ec       out  1  extra-clock pulse to P0 position counter
//  p1ec       out  1  extra-clock pulse to P1 position counter
//  m0ec       out  1  extra-clock pulse to M0 position counter
//  m1ec       out  1  extra-clock pulse to M1 position counter
//  blec       out  1  extra-clock pulse to BL position counter
//  hm_active  out  1  high while a motion sequence runs
//  hmove_blank out 1  high for BLANK_CLKS cycles after an HMOVE strobe
// BEHAVIOUR
//  - Reset: all motion regs = 4'h0, step = 0, phase = 0, FSM = IDLE. All
//    outputs are 0 in the cycle after reset is sampled. Reset mid-sequence
//    aborts it immediately, with no further ec pulses.
//  - Registers: xxhm strobe in cycle N loads d into that object's reg at the
//    clk edge ending cycle N. hmclr loads 0 into all five regs and has priority
//    over any xxhm strobe in the same cycle. Strobes are level-sampled, so a
//    strobe held for k cycles acts k times.
//  - Pulse count per object: cnt = reg ^ 4'b1000 (unsigned 0..15). Reg -8 gives
//    0 pulses, 0 gives 8, +7 gives 15.
//  - FSM IDLE -> RUN: hmove sampled in cycle N. From N+1: hm_active=1, step=0,
//    phase=0.
//  - RUN: phase counts 0..STEP_CLKS-1. At phase==STEP_CLKS-1, step increments.
//    After step NUM_STEPS-1 / last phase, FSM returns to IDLE. hm_active is high
//    for cycles N+1..N+64.
//  - ec pulses: in RUN with phase==0, xxec = (step < cnt), evaluated
//    combinationally from the current reg. Output is a 1-clk pulse, registered
//    (appears in the same cycle the phase==0 state is held). The pulse for step
//    k occurs at cycle N+1+4k.
//  - Write during RUN: the new reg value takes effect from the next compare slot
//    (real-TIA mid-HMOVE behaviour). No latching of cnt at start.
//  - hmove during RUN: restarts the sequence (step=0, phase=0 at next cycle) and
//    restarts hmove_blank.
//  - hmove_blank: high in cycles N+1..N+BLANK_CLKS, independent of FSM state.
//  - hmove and hmclr in the same cycle: regs clear first, so the sequence sees
//    cnt=8 for every object.
//  - ec outputs are 0 whenever FSM is IDLE.
// TESTING
//  - Reset then idle 100 clks -> all ec, hm_active and hmove_blank stay 0; regs
//    read 0.
//  - hmclr, then hmove at N -> each xxec pulses 8 times at N+1,N+5,...,N+29;
//    hm_active high N+1..N+64; hmove_blank high N+1..N+8.
//  - p0hm d=4'b0111, p1hm d=4'b1000, hmove -> p0ec 15 pulses (last at N+57),
//    p1ec none.
//  - m0hm d=4'b1000, hmove at N, m0hm d=4'b0111 at N+10 -> m0ec pulses at N+13
//    through N+57 (12 pulses).
//  - hmove at N and again at N+20 -> sequence restarts; with cnt=8, pulses at
//    N+1..N+17 then N+21..N+49; hm_active high through N+84.
//  - reset asserted at N+15 of a running sequence -> no ec after N+15; outputs 0
//    from N+16; regs 0.

Source files
------------

// File: rtl/tia_horizontal_motion.sv
// tia_horizontal_motion: HMOVE engine for the TIA core.
// Holds the five 4-bit motion registers. On an HMOVE strobe it runs a 16-slot
// compare sequence that emits extra-clock pulses to the object position
// counters, and it raises a short HMOVE blank window.
module tia_horizontal_motion #(
  parameter int STEP_CLKS  = 4,
  parameter int NUM_STEPS  = 16,
  parameter int BLANK_CLKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  input  logic       p0hm,
  input  logic       p1hm,
  input  logic       m0hm,
  input  logic       m1hm,
  input  logic       blhm,
  input  logic       hmove,
  input  logic       hmclr,
  output logic       p0ec,
  output logic       p1ec,
  output logic       m0ec,
  output logic       m1ec,
  output logic       blec,
  output logic       hm_active,
  output logic       hmove_blank
);

  localparam int PW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int BW = $clog2(BLANK_CLKS + 1);

  localparam logic [PW-1:0] LAST_PHASE = PW'(STEP_CLKS - 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(NUM_STEPS - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CLKS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [SW-1:0] step, step_nxt;
  logic [PW-1:0] phase, phase_nxt;

  // Object order everywhere: 0=P0, 1=P1, 2=M0, 3=M1, 4=BL.
  logic [4:0]      wr;
  logic [4:0][3:0] hm_reg, hm_nxt;
  logic [4:0]      ec_q, ec_nxt;
  logic [BW-1:0]   blank_cnt;

  assign wr = {blhm, m1hm, m0hm, p1hm, p0hm};

  // Next value of the motion registers; a clear wins over any write strobe.
  always_comb begin
    hm_nxt = hm_reg;
    if (hmclr) begin
      hm_nxt = '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr[i]) hm_nxt[i] = d;
      end
    end
  end

  // Motion register storage.
  always_ff @(posedge clk) begin
    if (reset) hm_reg <= '0;
    else       hm_reg <= hm_nxt;
  end

  // Sequencer next state: hmove (re)starts at slot 0, otherwise walk phase/step.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    phase_nxt = phase;
    if (hmove) begin
      state_nxt = RUN;
      step_nxt  = '0;
      phase_nxt = '0;
    end else if (state == RUN) begin
      if (phase == LAST_PHASE) begin
        phase_nxt = '0;
        if (step == LAST_STEP) begin
          state_nxt = IDLE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + SW'(1);
        end
      end else begin
        phase_nxt = phase + PW'(1);
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      phase <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      phase <= phase_nxt;
    end
  end

  // Compare slot decision for the upcoming cycle, using the register values
  // that will be in force then so writes and clears land in the next slot.
  always_comb begin
    ec_nxt = '0;
    if (state_nxt == RUN && phase_nxt == '0) begin
      for (int i = 0; i < 5; i++) begin
        ec_nxt[i] = 32'(step_nxt) < 32'(hm_nxt[i] ^ 4'b1000);
      end
    end
  end

  // Registered extra-clock pulses, aligned with the phase-0 cycle.
  always_ff @(posedge clk) begin
    if (reset) ec_q <= '0;
    else       ec_q <= ec_nxt;
  end

  // Blank window counter, restarted by every hmove regardless of sequencer.
  always_ff @(posedge clk) begin
    if (reset)                 blank_cnt <= '0;
    else if (hmove)            blank_cnt <= BLANK_LOAD;
    else if (blank_cnt != '0)  blank_cnt <= blank_cnt - BW'(1);
  end

  assign p0ec        = ec_q[0];
  assign p1ec        = ec_q[1];
  assign m0ec        = ec_q[2];
  assign m1ec        = ec_q[3];
  assign blec        = ec_q[4];
  assign hm_active   = (state == RUN);
  assign hmove_blank = (blank_cnt != '0);

endmodule

// File: tb/tb_tia_horizontal_motion.sv
// tb_tia_horizontal_motion: scoreboard bench for the HMOVE engine.
module tb_tia_horizontal_motion;

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic       p0hm, p1hm, m0hm, m1hm, blhm, hmove, hmclr;
  logic       p0ec, p1ec, m0ec, m1ec, blec, hm_active, hmove_blank;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_no = 0;

  // Reference state: motion regs, cycles since sequence start (-1 idle), blank count.
  logic [3:0] m_reg [5];
  int         m_t = -1;
  int         m_bt = 0;
  logic [6:0] exp_q [$];
  int         pulse_cnt [5];

  tia_horizontal_motion dut (
    .clk(clk), .reset(reset), .d(d),
    .p0hm(p0hm), .p1hm(p1hm), .m0hm(m0hm), .m1hm(m1hm), .blhm(blhm),
    .hmove(hmove), .hmclr(hmclr),
    .p0ec(p0ec), .p1ec(p1ec), .m0ec(m0ec), .m1ec(m1ec), .blec(blec),
    .hm_active(hm_active), .hmove_blank(hmove_blank)
  );

  // Free-running colour clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic clearPulses();
    for (int i = 0; i < 5; i++) pulse_cnt[i] = 0;
  endtask

  // One cycle: drive inputs, push the expected next-cycle outputs, clock, compare.
  // hm bit i selects the write strobe for object i (0=P0 .. 4=BL).
  task automatic applyStimulus(input logic rst, input logic [3:0] dv, input logic [4:0] hm,
                               input logic hmv, input logic clr);
    logic [6:0] e;
    logic [6:0] got;
    int cnt;
    reset = rst; d = dv;
    p0hm = hm[0]; p1hm = hm[1]; m0hm = hm[2]; m1hm = hm[3]; blhm = hm[4];
    hmove = hmv; hmclr = clr;
    e = '0;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 4'h0;
      m_t = -1;
      m_bt = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (clr) m_reg[i] = 4'h0;
        else if (hm[i]) m_reg[i] = dv;
      end
      if (hmv) m_t = 0;
      else if (m_t >= 0) m_t = (m_t == 63) ? -1 : m_t + 1;
      if (hmv) m_bt = 8;
      else if (m_bt > 0) m_bt--;
      for (int i = 0; i < 5; i++) begin
        cnt = int'({1'b0, ~m_reg[i][3], m_reg[i][2:0]});
        e[6-i] = (m_t >= 0) && (m_t % 4 == 0) && (m_t / 4 < cnt);
      end
      e[1] = (m_t >= 0);
      e[0] = (m_bt > 0);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cycle_no++;
    got = {p0ec, p1ec, m0ec, m1ec, blec, hm_active, hmove_blank};
    for (int i = 0; i < 5; i++) if (got[6-i]) pulse_cnt[i]++;
    checkOutput($sformatf("cycle%0d_outs", cycle_no), 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'h0, 5'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; d = '0;
    p0hm = 0; p1hm = 0; m0hm = 0; m1hm = 0; blhm = 0; hmove = 0; hmclr = 0;
    clearPulses();

    // Reset and long idle: everything quiet.
    applyStimulus(1'b1, 4'h0, 5'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h0, 5'b0, 1'b0, 1'b0);
    clearPulses();
    idle(100);
    checkOutput("idle_p0_pulses", 32'(pulse_cnt[0]), 32'd0);

    // Cleared regs: 8 pulses per object.
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b0, 1'b1);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(70);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("clr_obj%0d_pulses", i), 32'(pulse_cnt[i]), 32'd8);

    // Extremes: +7 gives 15 pulses, -8 gives none.
    applyStimulus(1'b0, 4'b0111, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1000, 5'b00010, 1'b0, 1'b0);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(70);
    checkOutput("p0_max_pulses", 32'(pulse_cnt[0]), 32'd15);
    checkOutput("p1_min_pulses", 32'(pulse_cnt[1]), 32'd0);

    // Write during the sequence takes effect at the next compare slot.
    applyStimulus(1'b0, 4'b1000, 5'b00100, 1'b0, 1'b0);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(9);
    applyStimulus(1'b0, 4'b0111, 5'b00100, 1'b0, 1'b0);
    idle(60);
    checkOutput("m0_midrun_pulses", 32'(pulse_cnt[2]), 32'd12);

    // Restart mid-sequence: 5 pulses before restart plus 8 after.
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b0, 1'b1);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(19);
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(70);
    checkOutput("restart_bl_pulses", 32'(pulse_cnt[4]), 32'd13);

    // Held strobe acts every cycle; then hmove+hmclr together sees cnt=8.
    applyStimulus(1'b0, 4'b1000, 5'b01000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0111, 5'b01000, 1'b0, 1'b0);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b1);
    idle(70);
    checkOutput("hmclr_hmove_m1_pulses", 32'(pulse_cnt[3]), 32'd8);

    // Reset mid-sequence aborts and clears the regs.
    applyStimulus(1'b0, 4'b0111, 5'b00001, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(14);
    clearPulses();
    applyStimulus(1'b1, 4'h0, 5'b0, 1'b0, 1'b0);
    idle(10);
    checkOutput("post_reset_pulses", 32'(pulse_cnt[0]), 32'd0);
    clearPulses();
    applyStimulus(1'b0, 4'h0, 5'b0, 1'b1, 1'b0);
    idle(70);
    checkOutput("post_reset_p0_reg0", 32'(pulse_cnt[0]), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
